// File: rtl/uart_rx.sv
// 8N1 UART receiver, 16x oversampled, for the MMIO trace/debug path.
// Baud = clk / ((div_i+1)*16); rx_i is synchronised before any decision is made.
module uart_rx (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [10:0] div_i,
    input  logic        rx_i,
    output logic [7:0]  data_o,
    output logic        rx_done_o,
    output logic        frame_err_o,
    output logic        busy_o
);

    localparam int unsigned DIV_W  = 11;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned SCNT_W = 4;
    localparam int unsigned BCNT_W = 3;

    localparam logic [SCNT_W-1:0] MID_START = SCNT_W'(7);
    localparam logic [SCNT_W-1:0] MID_BIT   = SCNT_W'(15);
    localparam logic [BCNT_W-1:0] LAST_BIT  = BCNT_W'(7);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } state_t;

    state_t              state;
    logic                rx_meta;
    logic                rx_s;
    logic [DIV_W-1:0]    sample_div;
    logic [SCNT_W-1:0]   sample_cnt;
    logic [BCNT_W-1:0]   bit_cnt;
    logic [DATA_W-1:0]   shift;
    logic                tick;

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
        end
    end

    assign tick = (state != IDLE) && (sample_div == div_i);

    // Frame FSM with divider, counters, shift register and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            sample_div  <= '0;
            sample_cnt  <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            data_o      <= '0;
            rx_done_o   <= 1'b0;
            frame_err_o <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            rx_done_o   <= 1'b0;
            frame_err_o <= 1'b0;

            if (state == IDLE || tick) begin
                sample_div <= '0;
            end else begin
                sample_div <= sample_div + DIV_W'(1);
            end

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state      <= START;
                        sample_cnt <= '0;
                        busy_o     <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        if (sample_cnt == MID_START) begin
                            if (!rx_s) begin
                                state      <= DATA;
                                sample_cnt <= '0;
                                bit_cnt    <= '0;
                            end else begin
                                state  <= IDLE;
                                busy_o <= 1'b0;
                            end
                        end else begin
                            sample_cnt <= sample_cnt + SCNT_W'(1);
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (sample_cnt == MID_BIT) begin
                            shift      <= {rx_s, shift[DATA_W-1:1]};
                            sample_cnt <= '0;
                            if (bit_cnt == LAST_BIT) begin
                                state <= STOP;
                            end else begin
                                bit_cnt <= bit_cnt + BCNT_W'(1);
                            end
                        end else begin
                            sample_cnt <= sample_cnt + SCNT_W'(1);
                        end
                    end
                end
                STOP: begin
                    // Leave at mid-stop so a back-to-back start edge is not missed.
                    if (tick) begin
                        if (sample_cnt == MID_BIT) begin
                            if (rx_s) begin
                                data_o    <= shift;
                                rx_done_o <= 1'b1;
                            end else begin
                                frame_err_o <= 1'b1;
                            end
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end else begin
                            sample_cnt <= sample_cnt + SCNT_W'(1);
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboarded bench for uart_rx: frames are queued as they are driven and a
// monitor checks every rx_done_o / frame_err_o pulse against the queue head.
`timescale 1ns/1ps
module tb_uart_rx;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [10:0] div_i;
    logic        rx_i;
    logic [7:0]  data_o;
    logic        rx_done_o;
    logic        frame_err_o;
    logic        busy_o;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        longint     due;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    longint      cyc = 0;
    logic [7:0]  last_good = 8'h00;

    uart_rx dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .div_i       (div_i),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .rx_done_o   (rx_done_o),
        .frame_err_o (frame_err_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int bit_clks();
        return 16 * (int'(div_i) + 1);
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic drive_bit(input logic v);
        rx_i = v;
        wait_clks(bit_clks());
    endtask

    // Reference: a frame resolves 9.5 bit times after its start edge, plus
    // synchroniser, idle-detect and output-register delay (3 clocks).
    task automatic send_frame(input logic [7:0] d, input logic stop_ok);
        exp_t e;
        e.is_err = !stop_ok;
        if (stop_ok) last_good = d;
        e.data = last_good;
        e.due  = cyc + 3 + longint'(152 * (int'(div_i) + 1));
        sb.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop_ok);
        rx_i = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy_o && n < 5000) begin
            @(negedge clk_i);
            n++;
        end
        check(name, 64'(busy_o), 64'd0);
    endtask

    // Starts a 0x55 frame and resets the DUT half-way through data bit 4.
    task automatic reset_mid_frame();
        logic [7:0] d = 8'h55;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        rx_i = d[4];
        wait_clks(bit_clks() / 2);
        rst_ni = 1'b0;
        rx_i   = 1'b1;
        wait_clks(4);
        check("mid_reset_busy", 64'(busy_o), 64'd0);
        check("mid_reset_data", 64'(data_o), 64'h00);
        rst_ni    = 1'b1;
        last_good = 8'h00;
        wait_clks(2 * bit_clks());
        send_frame(8'h81, 1'b1);
        wait_clks(2 * bit_clks());
        wait_idle("mid_reset_idle");
        check("after_reset_frame", 64'(data_o), 64'h81);
    endtask

    // Monitor: every output pulse must match the oldest outstanding frame.
    always @(negedge clk_i) begin
        if (rx_done_o && frame_err_o) begin
            vectors++;
            miscompares++;
            $display("FAIL both_pulses: rx_done_o and frame_err_o high together (cycle %0d)", cyc);
        end else if (rx_done_o || frame_err_o) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL spurious_pulse: done=%0b err=%0b with nothing expected (cycle %0d)",
                         rx_done_o, frame_err_o, cyc);
            end else begin
                exp_t e;
                longint diff;
                e = sb.pop_front();
                check("pulse_kind_err", 64'(frame_err_o), 64'(e.is_err));
                check("data_o", 64'(data_o), 64'(e.data));
                diff = cyc - e.due;
                vectors++;
                if (diff > 2 || diff < -2) begin
                    miscompares++;
                    $display("FAIL latency: pulse at cycle %0d, expected %0d +/-2", cyc, e.due);
                end
            end
        end
    end

    initial begin
        int n;
        rst_ni = 1'b0;
        rx_i   = 1'b1;
        div_i  = 11'd3;
        wait_clks(5);
        check("reset_data", 64'(data_o), 64'h00);
        check("reset_busy", 64'(busy_o), 64'd0);
        check("reset_done", 64'(rx_done_o), 64'd0);
        check("reset_err",  64'(frame_err_o), 64'd0);
        rst_ni = 1'b1;

        wait_clks(200);
        check("idle_busy", 64'(busy_o), 64'd0);
        check("idle_data", 64'(data_o), 64'h00);

        send_frame(8'hA5, 1'b1);
        wait_clks(2 * bit_clks());
        wait_idle("a5_idle");
        check("a5_data", 64'(data_o), 64'hA5);

        // Short low glitch: must start, then reject as a false start.
        rx_i = 1'b0;
        wait_clks(16);
        rx_i = 1'b1;
        n = 0;
        while (!busy_o && n < 8) begin
            @(negedge clk_i);
            n++;
        end
        check("glitch_busy_seen", 64'(busy_o), 64'd1);
        wait_idle("glitch_idle");
        wait_clks(bit_clks());

        send_frame(8'h3C, 1'b0);
        wait_clks(2 * bit_clks());
        wait_idle("ferr_idle");
        check("ferr_data_kept", 64'(data_o), 64'hA5);

        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_clks(2 * bit_clks());
        wait_idle("b2b_idle");
        check("b2b_data", 64'(data_o), 64'hFF);

        reset_mid_frame();
        div_i = 11'd0;
        wait_clks(4);
        reset_mid_frame();

        // Randomised frames, divisors, stop bits and inter-frame gaps.
        for (int k = 0; k < 24; k++) begin
            logic [7:0] d;
            logic       ok;
            int         gap;
            d   = 8'($urandom);
            ok  = ($urandom_range(0, 3) != 0);
            send_frame(d, ok);
            gap = ok ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
            if (gap > 0) begin
                wait_clks(gap * bit_clks());
                wait_idle("rand_idle");
                if ($urandom_range(0, 1) == 1) div_i = 11'($urandom_range(0, 3));
            end
        end
        wait_clks(2 * bit_clks());
        wait_idle("final_idle");

        n = 0;
        while (sb.size() != 0 && n < 20000) begin
            @(negedge clk_i);
            n++;
        end
        while (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missing_pulse: expected err=%0b data 0x%0h by cycle %0d, no pulse arrived",
                     e.is_err, e.data, e.due);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
